// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity modes and default framing
// constants. The transmitter and the baud generator use the same defaults.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int DEFAULT_OVS       = 16;
  localparam int DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input. Both flops reset to
// RESET_VAL so that an idle-high line does not look active coming out of reset.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make both flops sample together, forming a real two-stage chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampled UART receiver with parity, framing and break reporting.
// Build option: define UART_RX_MAJORITY_EN for a 2-of-3 majority vote around each sample point.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int OVS       = DEFAULT_OVS,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1,
  parameter int LSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 s_tick,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 rx_done_flag,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int SW = $clog2(OVS);
  localparam int NW = $clog2(DATA_BITS);

  localparam logic [SW-1:0] S_LAST      = SW'(OVS - 1);
  localparam logic [NW-1:0] N_DATA_LAST = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] N_STOP_LAST = NW'(STOP_BITS - 1);

  logic                 rx_s;
  logic                 bit_in;
  rx_state_t            state;
  logic [SW-1:0]        s;
  logic [NW-1:0]        n;
  logic [DATA_BITS-1:0] shreg;
  logic                 armed;
  logic                 par_bit;
  logic                 stop0;
  logic                 perr_acc;
  logic                 ferr_acc;
  logic                 s_last;
  logic                 ferr_now;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Decisions fall one tick after the nominal mid point; since s restarts at each
  // decision, every later bit keeps the same one-tick offset.
  localparam logic [SW-1:0] S_START_DEC = SW'(OVS / 2);

  logic [1:0] hist;
  logic [2:0] win;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= 2'b11;
    end else if (s_tick && state != ST_IDLE) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign win    = {hist, rx_s};
  assign bit_in = (win[0] & win[1]) | (win[0] & win[2]) | (win[1] & win[2]);
`else
  localparam logic [SW-1:0] S_START_DEC = SW'(OVS / 2 - 1);

  assign bit_in = rx_s;
`endif

  assign s_last   = (s == S_LAST);
  assign ferr_now = ferr_acc | ~bit_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      s            <= '0;
      n            <= '0;
      shreg        <= '0;
      armed        <= 1'b1;
      par_bit      <= 1'b0;
      stop0        <= 1'b0;
      perr_acc     <= 1'b0;
      ferr_acc     <= 1'b0;
      d_out        <= '0;
      rx_done_flag <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      rx_done_flag <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;

      case (state)
        ST_IDLE: begin
          s <= '0;
          n <= '0;
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state    <= ST_START;
            par_bit  <= 1'b0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
          end
        end

        ST_START: if (s_tick) begin
          if (s == S_START_DEC) begin
            s     <= '0;
            state <= bit_in ? ST_IDLE : ST_DATA;
          end else begin
            s <= s + 1'b1;
          end
        end

        ST_DATA: if (s_tick) begin
          if (s_last) begin
            s <= '0;
            if (LSB_FIRST != 0) shreg <= {bit_in, shreg[DATA_BITS-1:1]};
            else                shreg <= {shreg[DATA_BITS-2:0], bit_in};
            if (n == N_DATA_LAST) begin
              n     <= '0;
              state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              n <= n + 1'b1;
            end
          end else begin
            s <= s + 1'b1;
          end
        end

        ST_PARITY: if (s_tick) begin
          if (s_last) begin
            s        <= '0;
            par_bit  <= bit_in;
            perr_acc <= (^shreg ^ bit_in) != (PARITY == PAR_ODD);
            state    <= ST_STOP;
          end else begin
            s <= s + 1'b1;
          end
        end

        ST_STOP: if (s_tick) begin
          if (s_last) begin
            s <= '0;
            if (n == '0) stop0 <= bit_in;
            if (n == N_STOP_LAST) begin
              n            <= '0;
              state        <= ST_IDLE;
              rx_done_flag <= 1'b1;
              d_out        <= shreg;
              parity_err   <= perr_acc;
              frame_err    <= ferr_now;
              break_det    <= (shreg == '0) && !par_bit && ((n == '0) ? !bit_in : !stop0);
              // A framing error must see the line high before the next start is trusted.
              if (ferr_now) armed <= 1'b0;
            end else begin
              n        <= n + 1'b1;
              ferr_acc <= ferr_now;
            end
          end else begin
            s <= s + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: three configurations (8N1, 8E1, 7-bit MSB-first
// with two stop bits) driven by directed and random frames against a frame-level model.
module tb_uart_rx_param;
  import uart_pkg::*;

  typedef struct packed {
    logic [8:0] d;
    logic       p;
    logic       f;
    logic       b;
  } rec_t;

  logic       clk = 1'b0;
  logic       s_tick = 1'b0;
  int         tick_div = 0;
  logic [2:0] rx = '1;
  logic [2:0] rst = '1;

  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [2:0] done, perr, ferr, brk;

  int n_assert = 0;
  int n_fail   = 0;
  int leak[3]  = '{0, 0, 0};
  rec_t q0[$], q1[$], q2[$];

  int cfg_db [3] = '{8, 8, 7};
  int cfg_ovs[3] = '{16, 16, 8};
  int cfg_par[3] = '{PAR_NONE, PAR_EVEN, PAR_NONE};
  int cfg_sb [3] = '{1, 1, 2};
  int cfg_lsb[3] = '{1, 1, 0};

  always #5 clk = ~clk;

  // Tick every third clock, changed on the falling edge so it is stable at the rising edge.
  always @(negedge clk) begin
    tick_div = (tick_div == 2) ? 0 : tick_div + 1;
    s_tick   = (tick_div == 0);
  end

  uart_rx_param #(.DATA_BITS(8), .OVS(16), .PARITY(PAR_NONE), .STOP_BITS(1), .LSB_FIRST(1)) u_8n1 (
    .clk(clk), .reset(rst[0]), .rx(rx[0]), .s_tick(s_tick), .d_out(d0),
    .rx_done_flag(done[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .break_det(brk[0])
  );

  uart_rx_param #(.DATA_BITS(8), .OVS(16), .PARITY(PAR_EVEN), .STOP_BITS(1), .LSB_FIRST(1)) u_8e1 (
    .clk(clk), .reset(rst[1]), .rx(rx[1]), .s_tick(s_tick), .d_out(d1),
    .rx_done_flag(done[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .break_det(brk[1])
  );

  uart_rx_param #(.DATA_BITS(7), .OVS(8), .PARITY(PAR_NONE), .STOP_BITS(2), .LSB_FIRST(0)) u_7n2 (
    .clk(clk), .reset(rst[2]), .rx(rx[2]), .s_tick(s_tick), .d_out(d2),
    .rx_done_flag(done[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .break_det(brk[2])
  );

  function automatic rec_t mk(input logic [8:0] d, input logic p, input logic f, input logic b);
    rec_t r;
    r.d = d; r.p = p; r.f = f; r.b = b;
    return r;
  endfunction

  // Capture every completion; any error flag seen without a completion is a leak.
  always @(negedge clk) begin
    if (done[0]) q0.push_back(mk({1'b0, d0}, perr[0], ferr[0], brk[0]));
    else if (perr[0] | ferr[0] | brk[0]) leak[0]++;
    if (done[1]) q1.push_back(mk({1'b0, d1}, perr[1], ferr[1], brk[1]));
    else if (perr[1] | ferr[1] | brk[1]) leak[1]++;
    if (done[2]) q2.push_back(mk({2'b0, d2}, perr[2], ferr[2], brk[2]));
    else if (perr[2] | ferr[2] | brk[2]) leak[2]++;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (s_tick !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic hold(input int inst, input logic v, input int ticks);
    rx[inst] = v;
    wait_ticks(ticks);
  endtask

  // Frame model: what the receiver must report for one transmitted frame.
  function automatic rec_t model(input int inst, input logic [8:0] data, input logic pbit,
                                 input logic [1:0] stops);
    logic [8:0] m;
    logic p, f, b;
    m = data & ((9'h1 << cfg_db[inst]) - 9'h1);
    p = 1'b0;
    if (cfg_par[inst] == PAR_EVEN) p = (($countones(m) + int'(pbit)) % 2) != 0;
    if (cfg_par[inst] == PAR_ODD)  p = (($countones(m) + int'(pbit)) % 2) != 1;
    f = !stops[0] || (cfg_sb[inst] == 2 && !stops[1]);
    b = (m == 9'h0) && (cfg_par[inst] == PAR_NONE || !pbit) && !stops[0];
    return mk(m, p, f, b);
  endfunction

  task automatic send_body(input int inst, input logic [8:0] data, input logic pbit,
                           input logic [1:0] stops);
    int ovs;
    ovs = cfg_ovs[inst];
    hold(inst, 1'b0, ovs);
    for (int i = 0; i < cfg_db[inst]; i++)
      hold(inst, data[(cfg_lsb[inst] != 0) ? i : cfg_db[inst] - 1 - i], ovs);
    if (cfg_par[inst] != PAR_NONE) hold(inst, pbit, ovs);
    for (int i = 0; i < cfg_sb[inst]; i++) hold(inst, stops[i], ovs);
  endtask

  task automatic send_frame(input int inst, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stops);
    send_body(inst, data, pbit, stops);
    hold(inst, 1'b1, 4);
  endtask

  task automatic take(input int inst, output int cnt, output rec_t r);
    r = '0;
    case (inst)
      0: begin cnt = q0.size(); if (cnt > 0) r = q0[0]; q0.delete(); end
      1: begin cnt = q1.size(); if (cnt > 0) r = q1[0]; q1.delete(); end
      default: begin cnt = q2.size(); if (cnt > 0) r = q2[0]; q2.delete(); end
    endcase
  endtask

  task automatic expect_frame(input int inst, input rec_t exp, input string tag);
    int   cnt;
    rec_t got;
    take(inst, cnt, got);
    check({tag, ".done_count"}, cnt, 1);
    if (cnt > 0) begin
      check({tag, ".d_out"},      got.d, exp.d);
      check({tag, ".parity_err"}, got.p, exp.p);
      check({tag, ".frame_err"},  got.f, exp.f);
      check({tag, ".break_det"},  got.b, exp.b);
    end
  endtask

  task automatic expect_none(input int inst, input string tag);
    int   cnt;
    rec_t got;
    take(inst, cnt, got);
    check({tag, ".done_count"}, cnt, 0);
  endtask

  initial begin
    logic [8:0] data;
    logic       pbit;
    logic [1:0] stops;

    rst = '1;
    rx  = '1;
    repeat (4) @(posedge clk);
    #1;
    check("reset.u0", {d0, done[0], perr[0], ferr[0], brk[0]}, 0);
    check("reset.u1", {d1, done[1], perr[1], ferr[1], brk[1]}, 0);
    check("reset.u2", {d2, done[2], perr[2], ferr[2], brk[2]}, 0);
    rst = '0;
    wait_ticks(4);

    // Plain 8N1 frame.
    send_frame(0, 9'h0A5, 1'b0, 2'b11);
    expect_frame(0, mk(9'h0A5, 1'b0, 1'b0, 1'b0), "8n1_a5");

    // Even parity, wrong then right parity bit.
    send_frame(1, 9'h03C, 1'b1, 2'b11);
    expect_frame(1, mk(9'h03C, 1'b1, 1'b0, 1'b0), "even_3c_p1");
    send_frame(1, 9'h03C, 1'b0, 2'b11);
    expect_frame(1, mk(9'h03C, 1'b0, 1'b0, 1'b0), "even_3c_p0");

    // Low stop bit, then line stays low for longer than a frame: no second start.
    send_body(0, 9'h055, 1'b0, 2'b10);
    hold(0, 1'b0, 16 * 12);
    expect_frame(0, mk(9'h055, 1'b0, 1'b1, 1'b0), "stop_low_55");
    hold(0, 1'b1, 4);
    send_frame(0, 9'h012, 1'b0, 2'b11);
    expect_frame(0, mk(9'h012, 1'b0, 1'b0, 1'b0), "rearm_12");

    // Short low glitch is rejected at the start-bit check.
    hold(0, 1'b0, 4);
    hold(0, 1'b1, 16 * 12);
    expect_none(0, "glitch");
    send_frame(0, 9'h081, 1'b0, 2'b11);
    expect_frame(0, mk(9'h081, 1'b0, 1'b0, 1'b0), "after_glitch_81");

    // Break: line low for three frame times gives exactly one report.
    hold(0, 1'b0, 16 * 30);
    expect_frame(0, mk(9'h000, 1'b0, 1'b1, 1'b1), "break");
    hold(0, 1'b1, 16);
    send_frame(0, 9'h07E, 1'b0, 2'b11);
    expect_frame(0, mk(9'h07E, 1'b0, 1'b0, 1'b0), "after_break_7e");
    hold(0, 1'b1, 32);
    check("hold.d_out", d0, 32'h7E);

    // 7-bit MSB-first, two stop bits: good frame, then reset in the middle of data.
    send_frame(2, 9'h05A, 1'b0, 2'b11);
    expect_frame(2, mk(9'h05A, 1'b0, 1'b0, 1'b0), "7n2_5a");
    hold(2, 1'b0, 8);
    hold(2, 1'b1, 8);
    hold(2, 1'b0, 8);
    hold(2, 1'b1, 4);
    rst[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midreset.u2", {d2, done[2], perr[2], ferr[2], brk[2]}, 0);
    rst[2] = 1'b0;
    hold(2, 1'b1, 8 * 12);
    expect_none(2, "midreset");
    send_frame(2, 9'h02B, 1'b0, 2'b01);
    expect_frame(2, mk(9'h02B, 1'b0, 1'b1, 1'b0), "7n2_stop2_low");

    // Random frames on every configuration, checked against the frame model.
    for (int inst = 0; inst < 3; inst++) begin
      for (int k = 0; k < 8; k++) begin
        data  = 9'($urandom);
        if ($urandom_range(5) == 0) data = '0;
        pbit  = 1'($urandom);
        stops = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b11;
        send_frame(inst, data, pbit, stops);
        expect_frame(inst, model(inst, data, pbit, stops), $sformatf("rand_u%0d_%0d", inst, k));
      end
    end

    check("flag_leak.u0", leak[0], 0);
    check("flag_leak.u1", leak[1], 0);
    check("flag_leak.u2", leak[2], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
